// File: rtl/pc_pkg.sv
//------------------------------------------------------------------------------
// pc_pkg : shared types and default constants for the fetch-PC generator.
// Revision 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package pc_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_e;

  localparam int          XLEN_DEF      = 32;
  localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;
  localparam int          INC_DEF       = 4;
  localparam int          CNT_W_DEF     = 32;

endpackage

`default_nettype wire

// File: rtl/pc_fetch_gen_if.sv
//------------------------------------------------------------------------------
// pc_fetch_gen_if : fetch request, redirect, halt and status bundle.
// Revision 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface pc_fetch_gen_if
  import pc_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int CNT_W = CNT_W_DEF
);

  logic             fetch_valid;
  logic             fetch_ready;
  logic [XLEN-1:0]  fetch_pc;
  logic             redirect_valid;
  logic [XLEN-1:0]  redirect_pc;
  logic             halt_req;
  logic             halted;
  logic             fetch_flush;
  logic [CNT_W-1:0] fetch_count;
  logic             misalign;

  // master = the PC generator, slave = memory side plus redirect/halt source
  modport master (
    output fetch_valid, fetch_pc, halted, fetch_flush, fetch_count, misalign,
    input  fetch_ready, redirect_valid, redirect_pc, halt_req
  );

  modport slave (
    input  fetch_valid, fetch_pc, halted, fetch_flush, fetch_count, misalign,
    output fetch_ready, redirect_valid, redirect_pc, halt_req
  );

endinterface

`default_nettype wire

// File: rtl/pc_fetch_counter.sv
//------------------------------------------------------------------------------
// pc_fetch_counter : free-running wrap-around counter of accepted fetches.
// Revision 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pc_fetch_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/pc_fetch_gen.sv
//------------------------------------------------------------------------------
// pc_fetch_gen : architectural fetch PC with handshake, redirect/flush, halt.
// Optional macro PC_MISALIGN_TRAP_EN: reject misaligned redirects, pulse misalign.
// Revision 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pc_fetch_gen
  import pc_pkg::*;
#(
  parameter int              XLEN       = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_VEC  = XLEN'(RESET_VEC_DEF),
  parameter int              INC        = INC_DEF,
  parameter int              ALIGN_BITS = $clog2(INC),
  parameter int              CNT_W      = CNT_W_DEF
) (
  input  logic           clk,
  input  logic           reset,
  pc_fetch_gen_if.master bus
);

  localparam logic [1:0] S_BOOT = BOOT;
  localparam logic [1:0] S_RUN  = RUN;
  localparam logic [1:0] S_HALT = HALT;

  localparam logic [XLEN-1:0] C_INC      = XLEN'(INC);
  localparam logic [XLEN-1:0] C_LOW_MASK = XLEN'((1 << ALIGN_BITS) - 1);
  localparam logic [XLEN-1:0] C_RESET_PC = RESET_VEC & ~C_LOW_MASK;

  logic [1:0]       r_state;
  logic [XLEN-1:0]  r_pc;
  logic             r_valid;
  logic             r_halted;
  logic             r_flush;

  logic [1:0]       w_state_nxt;
  logic             w_accept;
  logic             w_redir_live;
  logic             w_redir_bad;
  logic             w_redir_take;
  logic [XLEN-1:0]  w_redir_target;
  logic [CNT_W-1:0] w_count;

  always_comb begin
    w_accept       = r_valid & bus.fetch_ready;
    w_redir_live   = bus.redirect_valid & (r_state != S_BOOT);
    w_redir_target = bus.redirect_pc & ~C_LOW_MASK;
`ifdef PC_MISALIGN_TRAP_EN
    w_redir_bad    = w_redir_live & (|(bus.redirect_pc & C_LOW_MASK));
`else
    w_redir_bad    = 1'b0;
`endif
    w_redir_take   = w_redir_live & ~w_redir_bad;
  end

  // RUN always presents a request, so a halt there either rides an accept or
  // a stalled cycle; both finish their PC update before entering HALT.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_BOOT:  w_state_nxt = bus.halt_req ? S_HALT : S_RUN;
      S_RUN:   w_state_nxt = bus.halt_req ? S_HALT : S_RUN;
      S_HALT:  w_state_nxt = bus.halt_req ? S_HALT : S_RUN;
      default: w_state_nxt = S_BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_BOOT;
      r_pc     <= C_RESET_PC;
      r_valid  <= 1'b0;
      r_halted <= 1'b0;
      r_flush  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_valid  <= (w_state_nxt == S_RUN);
      r_halted <= (w_state_nxt == S_HALT);
      r_flush  <= w_redir_take;
      // a redirect wins; an accept in the same cycle is counted but not stepped
      if (w_redir_take) begin
        r_pc <= w_redir_target;
      end else if (w_accept) begin
        r_pc <= r_pc + C_INC;
      end
    end
  end

`ifdef PC_MISALIGN_TRAP_EN
  logic r_misalign;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= w_redir_bad;
    end
  end

  assign bus.misalign = r_misalign;
`else
  assign bus.misalign = w_redir_bad;
`endif

  pc_fetch_counter #(
    .CNT_W (CNT_W)
  ) u_fetch_counter (
    .clk   (clk),
    .reset (reset),
    .en    (w_accept),
    .count (w_count)
  );

  assign bus.fetch_valid = r_valid;
  assign bus.fetch_pc    = r_pc;
  assign bus.halted      = r_halted;
  assign bus.fetch_flush = r_flush;
  assign bus.fetch_count = w_count;

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_gen.sv
//------------------------------------------------------------------------------
// tb_pc_fetch_gen : directed self-checking bench for pc_fetch_gen.
// Revision 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_pc_fetch_gen;

  logic clk;
  logic reset;
  logic reset_w;
  int   total;
  int   bad;

  pc_fetch_gen_if #(.XLEN(32), .CNT_W(32)) bus ();
  pc_fetch_gen_if #(.XLEN(32), .CNT_W(32)) bus_w ();

  pc_fetch_gen #(
    .XLEN      (32),
    .RESET_VEC (32'h0000_0000),
    .INC       (4),
    .CNT_W     (32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  pc_fetch_gen #(
    .XLEN      (32),
    .RESET_VEC (32'hFFFF_FFFC),
    .INC       (4),
    .CNT_W     (32)
  ) dut_w (
    .clk   (clk),
    .reset (reset_w),
    .bus   (bus_w)
  );

  // {valid, halted, flush, misalign, pc, count}
  logic [67:0] obs;
  logic [67:0] obs_w;
  logic [67:0] exp_v;

  assign obs   = {bus.fetch_valid, bus.halted, bus.fetch_flush, bus.misalign,
                  bus.fetch_pc, bus.fetch_count};
  assign obs_w = {bus_w.fetch_valid, bus_w.halted, bus_w.fetch_flush, bus_w.misalign,
                  bus_w.fetch_pc, bus_w.fetch_count};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic test_reset();
    reset = 1'b1;
    reset_w = 1'b1;
    bus.fetch_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    bus.halt_req = 1'b0;
    bus_w.fetch_ready = 1'b1;
    bus_w.redirect_valid = 1'b0;
    bus_w.redirect_pc = '0;
    bus_w.halt_req = 1'b0;
    repeat (3) @(negedge clk);
    exp_v = {4'b0000, 32'h0000_0000, 32'd0};
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL reset_state act=%h exp=%h", obs, exp_v);
    end
    exp_v = {4'b0000, 32'hFFFF_FFFC, 32'd0};
    total++;
    if (obs_w !== exp_v) begin
      bad++;
      $display("FAIL reset_state_vec act=%h exp=%h", obs_w, exp_v);
    end
  endtask

  task automatic test_boot();
    reset = 1'b0;
    bus.fetch_ready = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h0000_3000;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    exp_v = {4'b1000, 32'h0000_0000, 32'd0};
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL boot_first_run act=%h exp=%h", obs, exp_v);
    end
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      exp_v = {4'b1000, 32'(i * 4), 32'(i)};
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL seq_accept_%0d act=%h exp=%h", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_stall();
    @(negedge clk);
    exp_v = {4'b1000, 32'h0000_0010, 32'd4};
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL stall_pre act=%h exp=%h", obs, exp_v);
    end
    bus.fetch_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL stall_hold_%0d act=%h exp=%h", i, obs, exp_v);
      end
    end
    bus.fetch_ready = 1'b1;
    @(negedge clk);
    exp_v = {4'b1000, 32'h0000_0014, 32'd5};
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL stall_release act=%h exp=%h", obs, exp_v);
    end
  endtask

  task automatic test_redirect();
    repeat (3) @(negedge clk);
    exp_v = {4'b1000, 32'h0000_0020, 32'd8};
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL redirect_pre act=%h exp=%h", obs, exp_v);
    end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h0000_2000;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    bus.fetch_ready = 1'b0;
    exp_v = {4'b1010, 32'h0000_2000, 32'd9};
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL redirect_with_accept act=%h exp=%h", obs, exp_v);
    end
    @(negedge clk);
    exp_v = {4'b1000, 32'h0000_2000, 32'd9};
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL redirect_flush_end act=%h exp=%h", obs, exp_v);
    end
  endtask

  task automatic test_halt();
    bus.halt_req = 1'b1;
    @(negedge clk);
    exp_v = {4'b0100, 32'h0000_2000, 32'd9};
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL halt_enter act=%h exp=%h", obs, exp_v);
    end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h0000_0400;
    bus.fetch_ready = 1'b1;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    bus.halt_req = 1'b0;
    exp_v = {4'b0110, 32'h0000_0400, 32'd9};
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL halt_redirect act=%h exp=%h", obs, exp_v);
    end
    @(negedge clk);
    exp_v = {4'b1000, 32'h0000_0400, 32'd9};
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL halt_resume act=%h exp=%h", obs, exp_v);
    end
    @(negedge clk);
    bus.halt_req = 1'b1;
    exp_v = {4'b1000, 32'h0000_0404, 32'd10};
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL resume_accept act=%h exp=%h", obs, exp_v);
    end
    @(negedge clk);
    bus.halt_req = 1'b0;
    bus.fetch_ready = 1'b0;
    exp_v = {4'b0100, 32'h0000_0408, 32'd11};
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL halt_with_accept act=%h exp=%h", obs, exp_v);
    end
    @(negedge clk);
    exp_v = {4'b1000, 32'h0000_0408, 32'd11};
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL halt_resume2 act=%h exp=%h", obs, exp_v);
    end
  endtask

  task automatic test_misalign();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h0000_1002;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
    exp_v = {4'b1001, 32'h0000_0408, 32'd11};
`else
    exp_v = {4'b1010, 32'h0000_1000, 32'd11};
`endif
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL misalign_redirect act=%h exp=%h", obs, exp_v);
    end
    @(negedge clk);
`ifdef PC_MISALIGN_TRAP_EN
    exp_v = {4'b1000, 32'h0000_0408, 32'd11};
`else
    exp_v = {4'b1000, 32'h0000_1000, 32'd11};
`endif
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL misalign_after act=%h exp=%h", obs, exp_v);
    end
  endtask

  task automatic test_reset_mid();
    bus.fetch_ready = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h0000_5000;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    exp_v = {4'b1010, 32'h0000_5000, 32'd12};
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL pre_reset act=%h exp=%h", obs, exp_v);
    end
    #1;
    reset = 1'b1;
    #1;
    exp_v = {4'b0000, 32'h0000_0000, 32'd0};
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL async_reset act=%h exp=%h", obs, exp_v);
    end
    bus.fetch_ready = 1'b0;
  endtask

  task automatic test_wrap();
    @(negedge clk);
    reset_w = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      exp_v = {4'b1000, 32'hFFFF_FFFC + 32'(i * 4), 32'(i)};
      total++;
      if (obs_w !== exp_v) begin
        bad++;
        $display("FAIL wrap_%0d act=%h exp=%h", i, obs_w, exp_v);
      end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_boot();
    test_stall();
    test_redirect();
    test_halt();
    test_misalign();
    test_reset_mid();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pc_fetch_gen.md
Name: pc_fetch_gen

Overview:
- Parametrised successor to the plain next-PC register.
- Owns the architectural fetch PC and issues fetch requests over a valid/ready handshake.
- Sequential increment, redirect with flush, halt/resume control and an accepted-fetch counter, all internal.
- Sits between the branch/trap resolution logic (redirect source) and the instruction memory interface.

Parameters:
- XLEN, 32, width of the PC and redirect target.
- RESET_VEC, 32'h0000_0000, PC value loaded on reset.
- INC, 4, byte increment per accepted fetch; power of two, 2 or 4.
- ALIGN_BITS, $clog2(INC), low PC bits forced to zero.
- CNT_W, 32, width of the accepted-fetch counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- fetch_valid  out  1  fetch request valid.
- fetch_ready  in  1  memory accepts the request this cycle.
- fetch_pc  out  XLEN  address of the current request.
- redirect_valid  in  1  branch/jump/trap target valid, single-cycle pulse.
- redirect_pc  in  XLEN  redirect target.
- halt_req  in  1  level; requests fetch to stop.
- halted  out  1  high while in HALT.
- fetch_flush  out  1  one-cycle pulse; the in-flight fetch is stale.
- fetch_count  out  CNT_W  number of accepted fetches since reset.
- misalign  out  1  misaligned-redirect pulse (see Optional Feature).

Behaviour:
- Reset (asynchronous, any time, including mid-handshake):
  - state=BOOT, fetch_pc=RESET_VEC with low ALIGN_BITS cleared.
  - fetch_valid=0, fetch_flush=0, halted=0, fetch_count=0, misalign=0.
- State BOOT:
  - Exactly one cycle after reset deasserts, with fetch_valid=0.
  - Then RUN if halt_req=0, else HALT.
- State RUN:
  - fetch_valid=1.
  - Accept = fetch_valid & fetch_ready. On accept: fetch_pc <= fetch_pc+INC (modulo 2^XLEN, wraps silently) and fetch_count <= fetch_count+1 (wraps at 2^CNT_W).
  - No accept: fetch_pc holds.
- Redirect (any state except BOOT; redirect in BOOT is dropped):
  - fetch_pc <= redirect_pc with low ALIGN_BITS cleared.
  - fetch_flush=1 in the following cycle.
  - Has priority over increment. A simultaneous accept is still counted, but its increment is discarded.
- Halt:
  - In RUN with halt_req=1: if accept or fetch_ready=0 this cycle, finish the current cycle's update, then HALT.
  - HALT: fetch_valid=0, halted=1.
  - Redirect in HALT updates fetch_pc; state stays HALT.
  - halt_req=0 in HALT: RUN next cycle, fetch_valid=1 from that cycle.
- Latency:
  - Redirect to new fetch_pc visible: 1 cycle.
  - Accept to next PC visible: 1 cycle.
- fetch_pc is stable while fetch_valid=1 and fetch_ready=0, unless a redirect occurs; the redirect plus fetch_flush signals the change.
- All outputs are registered.

Optional Feature:
- Macro: PC_MISALIGN_TRAP_EN.
- Enabled: a redirect_pc with any nonzero low ALIGN_BITS bit is ignored. fetch_pc is unchanged, no flush, and misalign pulses for 1 cycle the next cycle.
- Disabled: low bits are silently cleared and the redirect is taken; misalign is tied to 0.

Decomposition:
- Shared package pc_pkg:
  - State enum {BOOT, RUN, HALT}.
  - Default constants XLEN_DEF=32, RESET_VEC_DEF=32'h0, INC_DEF=4.
- Sub-module pc_fetch_counter: CNT_W wide, increment-enable, async active-high reset; instantiated once for fetch_count.

Test Plan:
- Reset, release, fetch_ready=1 held -> cycle 1 after release: fetch_valid=0, pc=0x0. Following cycles: pc=0x0, 0x4, 0x8. fetch_count reaches 3 after three accepts.
- fetch_ready=0 for 5 cycles at pc=0x10 -> pc holds 0x10, count unchanged. Ready returns -> pc=0x14 the next cycle.
- redirect_valid with redirect_pc=0x2000 in the same cycle as an accept at 0x20 -> next cycle pc=0x2000, fetch_flush=1 for one cycle, count incremented by 1.
- halt_req=1 in RUN -> HALT, fetch_valid=0, halted=1. Redirect to 0x400 while halted -> pc=0x400, still halted. halt_req=0 -> RUN with fetch_valid=1 at pc=0x400.
- RESET_VEC=0xFFFF_FFFC, accept -> pc wraps to 0x0000_0000. Asserting reset mid-handshake returns all outputs to their reset values immediately.
- redirect_pc=0x1002:
  - With PC_MISALIGN_TRAP_EN: pc unchanged, misalign=1 for one cycle, no flush.
  - Without it: pc=0x1000, fetch_flush=1.
